// File: rtl/reversi_accel_mul_pipe.sv
// reversi_accel_mul_pipe
//   Elastic pipelined multiplier for the reversi accelerator datapath.
//   Stage 1 captures the operands. The product is formed between stage 1 and
//   stage 2. Stages 2..NUM_STAGE carry the truncated product and its overflow
//   flag. Every stage has its own valid bit, so an empty stage refills even
//   while the stages after it are stalled.
//
//   Optional feature macro: REVERSI_MUL_ACC_EN
//     When it is defined, the in_acc port and a P_WIDTH accumulator are added.
//     An item flagged with in_acc is summed with the accumulator as it enters
//     the last stage. The accumulator always takes the value loaded into the
//     last stage.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   ce         global clock enable; 0 freezes every register
//   in_valid   din0/din1 (and in_acc) valid
//   in_ready   block accepts input this cycle (combinational from out_ready)
//   din0       multiplicand, A_WIDTH bits
//   din1       multiplier, B_WIDTH bits
//   in_acc     accumulate flag (REVERSI_MUL_ACC_EN builds only)
//   out_valid  dout/ovf valid
//   out_ready  consumer accepts dout
//   dout       low P_WIDTH bits of the result
//   ovf        result did not fit in P_WIDTH bits
module reversi_accel_mul_pipe #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int P_WIDTH   = 26,
  parameter int NUM_STAGE = 4,
  parameter int SIGNED_A  = 0,
  parameter int SIGNED_B  = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] din0,
  input  logic [B_WIDTH-1:0] din1,
`ifdef REVERSI_MUL_ACC_EN
  input  logic               in_acc,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [P_WIDTH-1:0] dout,
  output logic               ovf
);

  localparam int FULL_W     = A_WIDTH + B_WIDTH;
  localparam bit EXT_A      = (SIGNED_A != 0);
  localparam bit EXT_B      = (SIGNED_B != 0);
  localparam bit RES_SIGNED = EXT_A || EXT_B;

  logic [NUM_STAGE:1] valid_q;
  logic [NUM_STAGE:1] stageLoad;
  logic [A_WIDTH-1:0] opA_q;
  logic [B_WIDTH-1:0] opB_q;
  logic [P_WIDTH-1:0] prod_q [2:NUM_STAGE];
  logic [NUM_STAGE:2] ovf_q;

  logic [P_WIDTH-1:0] srcProd [2:NUM_STAGE];
  logic [NUM_STAGE:2] srcOvf;
  logic [P_WIDTH-1:0] lastProd_d;
  logic               lastOvf_d;

  logic [FULL_W-1:0]  opAFull;
  logic [FULL_W-1:0]  opBFull;
  logic [FULL_W-1:0]  fullProd;
  logic [FULL_W-1:0]  hiSigned;
  logic [FULL_W-1:0]  hiUnsigned;
  logic [P_WIDTH-1:0] mulP;
  logic               mulOvf;

  // The load chain is walked from the output back to the input. A stage
  // loads when it is empty or its current item moves on this cycle. This
  // lets bubbles collapse. It also makes in_ready a combinational function
  // of out_ready.
  always_comb begin
    logic downstreamLoad;
    logic ld;
    downstreamLoad = out_ready;
    stageLoad      = '0;
    for (int k = NUM_STAGE; k >= 1; k--) begin
      ld             = ce & (~valid_q[k] | downstreamLoad);
      stageLoad[k]   = ld;
      downstreamLoad = ld;
    end
  end

  assign in_ready  = stageLoad[1] & ~reset;
  assign out_valid = valid_q[NUM_STAGE];
  assign dout      = prod_q[NUM_STAGE];
  assign ovf       = ovf_q[NUM_STAGE];

  // Each operand is sign- or zero-extended to the full product width. The
  // low FULL_W bits of an unsigned multiply are then the exact two's
  // complement product for any mix of operand signedness.
  assign opAFull  = {{B_WIDTH{EXT_A & opA_q[A_WIDTH-1]}}, opA_q};
  assign opBFull  = {{A_WIDTH{EXT_B & opB_q[B_WIDTH-1]}}, opB_q};
  assign fullProd = opAFull * opBFull;
  assign mulP     = fullProd[P_WIDTH-1:0];

  // For a signed result, the bits from dout's sign bit upward must all match.
  // For an unsigned result, everything above dout must be zero.
  assign hiSigned   = $signed(fullProd) >>> (P_WIDTH - 1);
  assign hiUnsigned = fullProd >> P_WIDTH;
  assign mulOvf     = RES_SIGNED ? ~((hiSigned == '0) | (&hiSigned))
                                 : (hiUnsigned != '0);

  // Source values for each stage of the product pipeline.
  always_comb begin
    srcProd[2] = mulP;
    srcOvf[2]  = mulOvf;
    for (int k = 3; k <= NUM_STAGE; k++) begin
      srcProd[k] = prod_q[k-1];
      srcOvf[k]  = ovf_q[k-1];
    end
  end

`ifdef REVERSI_MUL_ACC_EN
  logic [NUM_STAGE-1:1] accFlag_q;
  logic [P_WIDTH-1:0]   acc_q;
  logic [P_WIDTH:0]     sumWide;
  logic                 sumOvf;

  assign sumWide = {1'b0, acc_q} + {1'b0, srcProd[NUM_STAGE]};
  assign sumOvf  = RES_SIGNED
                 ? ((acc_q[P_WIDTH-1] == srcProd[NUM_STAGE][P_WIDTH-1]) &&
                    (sumWide[P_WIDTH-1] != acc_q[P_WIDTH-1]))
                 : sumWide[P_WIDTH];

  // The accumulate decision is made as the item enters the last stage.
  // The flag therefore only needs to travel as far as stage NUM_STAGE-1.
  always_comb begin
    lastProd_d = srcProd[NUM_STAGE];
    lastOvf_d  = srcOvf[NUM_STAGE];
    if (accFlag_q[NUM_STAGE-1]) begin
      lastProd_d = sumWide[P_WIDTH-1:0];
      lastOvf_d  = srcOvf[NUM_STAGE] | sumOvf;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      accFlag_q <= '0;
      acc_q     <= '0;
    end else begin
      if (stageLoad[1] && in_valid) accFlag_q[1] <= in_acc;
      for (int k = 2; k <= NUM_STAGE - 1; k++) begin
        if (stageLoad[k] && valid_q[k-1]) accFlag_q[k] <= accFlag_q[k-1];
      end
      if (stageLoad[NUM_STAGE] && valid_q[NUM_STAGE-1]) acc_q <= lastProd_d;
    end
  end
`else
  always_comb begin
    lastProd_d = srcProd[NUM_STAGE];
    lastOvf_d  = srcOvf[NUM_STAGE];
  end
`endif

  // Valid bits follow the load chain; a bubble loads as an empty stage.
  // Data registers only capture real items. This keeps the last stage's
  // contents from toggling when no item is present.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      opA_q   <= '0;
      opB_q   <= '0;
      ovf_q   <= '0;
      for (int k = 2; k <= NUM_STAGE; k++) prod_q[k] <= '0;
    end else begin
      if (stageLoad[1]) valid_q[1] <= in_valid;
      if (stageLoad[1] && in_valid) begin
        opA_q <= din0;
        opB_q <= din1;
      end
      for (int k = 2; k <= NUM_STAGE; k++) begin
        if (stageLoad[k]) valid_q[k] <= valid_q[k-1];
      end
      for (int k = 2; k <= NUM_STAGE - 1; k++) begin
        if (stageLoad[k] && valid_q[k-1]) begin
          prod_q[k] <= srcProd[k];
          ovf_q[k]  <= srcOvf[k];
        end
      end
      if (stageLoad[NUM_STAGE] && valid_q[NUM_STAGE-1]) begin
        prod_q[NUM_STAGE] <= lastProd_d;
        ovf_q[NUM_STAGE]  <= lastOvf_d;
      end
    end
  end

endmodule

// File: tb/tb_reversi_accel_mul_pipe.sv
// Testbench for reversi_accel_mul_pipe.
// Two instances share all inputs: one with unsigned operands and one with
// signed operands (default widths, NUM_STAGE=4). Each accepted item is turned
// into expected results by an integer-arithmetic reference model. Those
// results are queued and compared in order as items leave the pipeline.
module tb_reversi_accel_mul_pipe;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        inValid;
  logic        outReady;
  logic [15:0] din0;
  logic [15:0] din1;
`ifdef REVERSI_MUL_ACC_EN
  logic        inAcc;
`endif
  logic        inReadyU, inReadyS;
  logic        outValidU, outValidS;
  logic [25:0] doutU, doutS;
  logic        ovfU, ovfS;

  always #5 clk = ~clk;

  reversi_accel_mul_pipe #(
    .A_WIDTH(16), .B_WIDTH(16), .P_WIDTH(26), .NUM_STAGE(N),
    .SIGNED_A(0), .SIGNED_B(0)
  ) dutU (
    .clk(clk), .reset(reset), .ce(ce),
    .in_valid(inValid), .in_ready(inReadyU),
    .din0(din0), .din1(din1),
`ifdef REVERSI_MUL_ACC_EN
    .in_acc(inAcc),
`endif
    .out_valid(outValidU), .out_ready(outReady),
    .dout(doutU), .ovf(ovfU)
  );

  reversi_accel_mul_pipe #(
    .A_WIDTH(16), .B_WIDTH(16), .P_WIDTH(26), .NUM_STAGE(N),
    .SIGNED_A(1), .SIGNED_B(1)
  ) dutS (
    .clk(clk), .reset(reset), .ce(ce),
    .in_valid(inValid), .in_ready(inReadyS),
    .din0(din0), .din1(din1),
`ifdef REVERSI_MUL_ACC_EN
    .in_acc(inAcc),
`endif
    .out_valid(outValidS), .out_ready(outReady),
    .dout(doutS), .ovf(ovfS)
  );

  typedef struct packed {
    logic [25:0] du;
    logic        ou;
    logic [25:0] ds;
    logic        os;
  } expT;

  expT         expQ[$];
  logic [25:0] seenU[$];
  logic [25:0] accU, accS;
  int          testCount = 0;
  int          failCount = 0;
  logic        lastInXfer, lastOutXfer, lastOutValid;
  logic        holdPending, prevCeLow, prevOutValid;
  logic [25:0] heldU, heldS;
  logic        heldOU, heldOS;
  logic [25:0] lastDoutU, lastDoutS;
  logic        lastOvfU, lastOvfS;

  // Counts one comparison and reports it when it does not match.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: full-precision integer products with range tests
  // against 26-bit unsigned and signed result ranges.
  task automatic pushExpected(input logic [15:0] a, input logic [15:0] b, input logic ac);
    longint pu, ps, su, ss;
    expT    e;
    pu   = longint'(a) * longint'(b);
    ps   = longint'($signed(a)) * longint'($signed(b));
    e.du = 26'(pu);
    e.ou = (pu >= (64'sd1 <<< 26));
    e.ds = 26'(ps);
    e.os = (ps < -(64'sd1 <<< 25)) || (ps >= (64'sd1 <<< 25));
`ifdef REVERSI_MUL_ACC_EN
    if (ac) begin
      su   = longint'(accU) + longint'(e.du);
      ss   = longint'($signed(accS)) + longint'($signed(e.ds));
      e.ou = e.ou | (su >= (64'sd1 <<< 26));
      e.os = e.os | (ss < -(64'sd1 <<< 25)) | (ss >= (64'sd1 <<< 25));
      e.du = 26'(su);
      e.ds = 26'(ss);
    end
`else
    su = longint'(ac);
    ss = su;
`endif
    accU = e.du;
    accS = e.ds;
    expQ.push_back(e);
  endtask

  // Drives one cycle at the falling edge, then scores that cycle's
  // handshakes and the hold/freeze rules.
  task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [15:0] b,
                               input logic ac, input logic c, input logic r);
    expT e;
    @(negedge clk);
    inValid  = v;
    din0     = a;
    din1     = b;
    ce       = c;
    outReady = r;
`ifdef REVERSI_MUL_ACC_EN
    inAcc    = ac;
`endif
    #1;
    lastInXfer   = inValid & inReadyU;
    lastOutXfer  = outValidU & outReady & ce;
    lastOutValid = outValidU;
    if (!ce) checkOutput("ceInReady", inReadyU, 0);
    if (prevCeLow) checkOutput("ceHoldValid", outValidU, prevOutValid);
    if (holdPending) begin
      checkOutput("holdValid", outValidU, 1);
      checkOutput("holdDoutU", doutU, heldU);
      checkOutput("holdOvfU", ovfU, heldOU);
      checkOutput("holdDoutS", doutS, heldS);
      checkOutput("holdOvfS", ovfS, heldOS);
    end
    if (lastOutXfer) begin
      if (expQ.size() == 0) begin
        checkOutput("spuriousOut", expQ.size(), 1);
      end else begin
        e = expQ.pop_front();
        checkOutput("doutU", doutU, e.du);
        checkOutput("ovfU", ovfU, e.ou);
        checkOutput("validS", outValidS, 1);
        checkOutput("doutS", doutS, e.ds);
        checkOutput("ovfS", ovfS, e.os);
        seenU.push_back(doutU);
        lastDoutU = doutU; lastOvfU = ovfU;
        lastDoutS = doutS; lastOvfS = ovfS;
      end
    end
    if (lastInXfer) begin
      checkOutput("readyS", inReadyS, 1);
      pushExpected(a, b, ac);
    end
    holdPending  = outValidU && !lastOutXfer;
    heldU = doutU; heldOU = ovfU; heldS = doutS; heldOS = ovfS;
    prevCeLow    = !ce;
    prevOutValid = outValidU;
  endtask

  task automatic sendItem(input logic [15:0] a, input logic [15:0] b, input logic ac);
    int n;
    n = 0;
    do begin
      applyStimulus(1'b1, a, b, ac, 1'b1, 1'b1);
      n++;
    end while (!lastInXfer && n < 20);
    checkOutput("sendAccepted", lastInXfer, 1);
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 40 && expQ.size() != 0; n++) applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b1);
    checkOutput(tag, expQ.size(), 0);
  endtask

  // Counts the cycles from the accepting handshake to the first out_valid.
  task automatic measureLatency(input logic [15:0] a, input logic [15:0] b, input string tag);
    int n;
    sendItem(a, b, 1'b0);
    n = 0;
    do begin
      applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b1);
      n++;
    end while (!lastOutValid && n < 20);
    checkOutput(tag, n, N);
  endtask

  task automatic pulseReset();
    #1;
    reset = 1'b1;
    #1;
    checkOutput("rstValidU", outValidU, 0);
    checkOutput("rstValidS", outValidS, 0);
    checkOutput("rstReadyU", inReadyU, 0);
    checkOutput("rstDoutU", doutU, 0);
    checkOutput("rstOvfS", ovfS, 0);
    expQ.delete();
    accU = '0; accS = '0;
    holdPending = 1'b0; prevCeLow = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int idx, acceptedAtStall;
    logic [15:0] ra, rb;
    reset = 1'b0; ce = 1'b1; inValid = 1'b0; outReady = 1'b1;
    din0 = '0; din1 = '0;
`ifdef REVERSI_MUL_ACC_EN
    inAcc = 1'b0;
`endif
    accU = '0; accS = '0;
    holdPending = 1'b0; prevCeLow = 1'b0; prevOutValid = 1'b0;
    lastDoutU = '0; lastDoutS = '0; lastOvfU = 1'b0; lastOvfS = 1'b0;
    #1 reset = 1'b1;
    #2;
    checkOutput("resetReadyU", inReadyU, 0);
    checkOutput("resetValidU", outValidU, 0);
    checkOutput("resetDoutU", doutU, 0);
    checkOutput("resetOvfU", ovfU, 0);
    checkOutput("resetValidS", outValidS, 0);
    @(posedge clk);
    #2 reset = 1'b0;

    // Directed vectors with known results
    measureLatency(16'hFFFF, 16'hFFFF, "latency");
    checkOutput("vecMaxDout", lastDoutU, 26'h3FE0001);
    checkOutput("vecMaxOvf", lastOvfU, 1);
    sendItem(16'd100, 16'd200, 1'b0); drain("drainSmall");
    checkOutput("vecSmallDout", lastDoutU, 26'h0004E20);
    checkOutput("vecSmallOvf", lastOvfU, 0);
    sendItem(16'hFFFF, 16'h0003, 1'b0); drain("drainNeg");
    checkOutput("vecNegDout", lastDoutS, 26'h3FFFFFD);
    checkOutput("vecNegOvf", lastOvfS, 0);
    sendItem(16'h8000, 16'h8000, 1'b0); drain("drainMin");
    checkOutput("vecMinOvf", lastOvfS, 1);

    // Back-to-back i*(i+1) with the consumer stalled for 6 cycles
    idx = 0; acceptedAtStall = 0;
    for (int cyc = 0; cyc < 80 && (idx < 8 || expQ.size() != 0); cyc++) begin
      applyStimulus(idx < 8, 16'(idx), 16'(idx + 1), 1'b0, 1'b1, cyc >= 6);
      if (lastInXfer) idx++;
      if (cyc == 5) acceptedAtStall = idx;
    end
    checkOutput("stallCapacity", acceptedAtStall, 4);
    checkOutput("b2bSent", idx, 8);
    checkOutput("b2bDrained", expQ.size(), 0);

    // Clock enable dropped for 3 cycles mid-stream
    idx = 0;
    for (int cyc = 0; cyc < 60 && (idx < 10 || expQ.size() != 0); cyc++) begin
      applyStimulus(idx < 10, 16'(idx * 37), 16'(1000 - idx), 1'b0, !(cyc >= 6 && cyc < 9), 1'b1);
      if (lastInXfer) idx++;
    end
    checkOutput("ceSent", idx, 10);
    checkOutput("ceDrained", expQ.size(), 0);

    // Reset with 3 items in flight
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'(i + 5), 16'd11, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("preResetValid", lastOutValid, 1);
    pulseReset();
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b1);
    measureLatency(16'd9, 16'd9, "latAfterReset");

`ifdef REVERSI_MUL_ACC_EN
    // Multiply-accumulate sequence
    pulseReset();
    seenU.delete();
    sendItem(16'd2, 16'd3, 1'b0);
    sendItem(16'd4, 16'd5, 1'b1);
    sendItem(16'd1, 16'd1, 1'b1);
    sendItem(16'd7, 16'd1, 1'b0);
    drain("accDrained");
    checkOutput("acc0", seenU[0], 6);
    checkOutput("acc1", seenU[1], 26);
    checkOutput("acc2", seenU[2], 27);
    checkOutput("acc3", seenU[3], 7);
`endif

    // Randomized traffic against the reference model
    for (int cyc = 0; cyc < 400; cyc++) begin
      case ($urandom_range(0, 3))
        0:       ra = 16'hFFFF;
        1:       ra = 16'h8000;
        default: ra = 16'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       rb = 16'h7FFF;
        1:       rb = 16'h0001;
        default: rb = 16'($urandom);
      endcase
      applyStimulus($urandom_range(0, 3) != 0, ra, rb, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0);
    end
    drain("finalDrain");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
